// File: rtl/cache_arbiter_if.sv
// One line-granular memory channel: a requester drives read/write/address/wdata
// and receives a single-cycle resp with rdata.
interface cache_arbiter_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);

    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resp;
    logic [DATA_WIDTH-1:0] rdata;

    // Requester side: issues the request, receives the completion.
    modport master (
        output read, write, address, wdata,
        input  resp, rdata
    );

    // Responder side: accepts the request, returns the completion.
    modport slave (
        input  read, write, address, wdata,
        output resp, rdata
    );

endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one backing-memory port between the I-cache (a) and the
// D-cache (b). The D-side wins ties; a streak counter bounds how long I-fetch waits.
module cache_arbiter #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int STREAK_MAX = 4     // legal range 1..15
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  a_if,
    cache_arbiter_if.slave  b_if,
    cache_arbiter_if.master mem_if
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

    localparam logic [3:0] STREAK_LIMIT = 4'(STREAK_MAX);

    state_e                state_q, state_d;
    logic [3:0]            streak_q, streak_d;
    logic                  req_a, req_b;
    logic                  grant_a, grant_b;
    logic [ADDR_WIDTH-1:0] fwd_address;
    logic [DATA_WIDTH-1:0] fwd_wdata;
    logic                  fwd_read, fwd_write;
    logic                  a_resp, b_resp;

    assign req_a = a_if.read | a_if.write;
    assign req_b = b_if.read | b_if.write;

    // b keeps priority until it has won STREAK_MAX grants in a row over a waiting a.
    always_comb begin
        grant_b = req_b && (!req_a || (streak_q < STREAK_LIMIT));
        grant_a = req_a && !grant_b;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (grant_b) begin
                    state_d = SERVE_B;
                    if (!req_a) begin
                        streak_d = 4'd0;
                    end else if (streak_q >= STREAK_LIMIT) begin
                        streak_d = STREAK_LIMIT;
                    end else begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (grant_a) begin
                    state_d  = SERVE_A;
                    streak_d = 4'd0;
                end
            end
            SERVE_A, SERVE_B: begin
                // No preemption: the granted side keeps the port until memory completes.
                if (mem_if.resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    // Forwarding is purely combinational from the registered state, so a reset
    // drops any in-flight request downstream immediately.
    always_comb begin
        fwd_read    = 1'b0;
        fwd_write   = 1'b0;
        fwd_address = b_if.address;
        fwd_wdata   = b_if.wdata;
        a_resp      = 1'b0;
        b_resp      = 1'b0;
        case (state_q)
            SERVE_A: begin
                fwd_read    = a_if.read;
                fwd_write   = a_if.write;
                fwd_address = a_if.address;
                fwd_wdata   = a_if.wdata;
                a_resp      = mem_if.resp;
            end
            SERVE_B: begin
                fwd_read    = b_if.read;
                fwd_write   = b_if.write;
                fwd_address = b_if.address;
                fwd_wdata   = b_if.wdata;
                b_resp      = mem_if.resp;
            end
            default: ;
        endcase
    end

    assign mem_if.read    = fwd_read;
    assign mem_if.write   = fwd_write;
    assign mem_if.address = fwd_address;
    assign mem_if.wdata   = fwd_wdata;
    assign a_if.resp      = a_resp;
    assign b_if.resp      = b_resp;
    assign a_if.rdata     = mem_if.rdata;
    assign b_if.rdata     = mem_if.rdata;

    a_one_resp: assert property (@(posedge clk) disable iff (!rst_n) !(a_if.resp && b_if.resp));

endmodule
